// File: rtl/hft_zero_plus.sv
// hft_zero_plus: single-shot market-making decision engine with an
// ap_start/ap_done/ap_idle/ap_ready block-level handshake.
//
// Ports:
//   ap_clk, ap_rst            clock, synchronous active-high reset
//   ap_start                  start request, sampled only in IDLE
//   ap_done                   one-cycle pulse, decision outputs valid
//   ap_idle, ap_ready         high in IDLE
//   best_bid_price/qty        top-of-book bid (cents / size)
//   best_ask_price/qty        top-of-book ask (cents / size)
//   bid_queue_strong          nonzero = strong bid queue
//   ask_queue_strong          nonzero = strong ask queue
//   current_position          signed inventory
//   last_fill_price/side      previous fill (price 0 = none; side 0/1/2)
//   action, price, quantity   registered decision (0 none, 1 buy, 2 sell)
module hft_zero_plus #(
    parameter int unsigned ORDER_QTY  = 10,
    parameter int unsigned MAX_POS    = 100,
    parameter int unsigned MIN_SPREAD = 2,
    parameter int unsigned TICK       = 1
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic [31:0] best_bid_price,
    input  logic [31:0] best_ask_price,
    input  logic [31:0] best_bid_qty,
    input  logic [31:0] best_ask_qty,
    input  logic [31:0] bid_queue_strong,
    input  logic [31:0] ask_queue_strong,
    input  logic [31:0] current_position,
    input  logic [31:0] last_fill_price,
    input  logic [31:0] last_fill_side,
    output logic [31:0] action,
    output logic [31:0] price,
    output logic [31:0] quantity
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_COMPUTE,
        S_DONE
    } state_t;

    localparam logic [31:0]        QTY32    = 32'(ORDER_QTY);
    localparam logic [31:0]        TICK32   = 32'(TICK);
    localparam logic [31:0]        SPREAD32 = 32'(MIN_SPREAD);
    localparam logic signed [32:0] QTY_S    = 33'(ORDER_QTY);
    localparam logic signed [32:0] MAX_S    = 33'(MAX_POS);

    state_t state;

    // Captured snapshot; book quantities are captured for completeness but
    // do not influence the decision.
    logic [31:0] c_bid, c_ask, c_bid_qty, c_ask_qty;
    logic [31:0] c_pos, c_lfp, c_lfs;
    logic        c_bstr, c_astr;

    logic [31:0]        spread, buy_px, sell_px, long_qty, short_qty;
    logic signed [32:0] pos_s, neg_pos;
    logic               invalid;
    logic [31:0]        n_action, n_price, n_qty;

    assign ap_idle  = (state == S_IDLE);
    assign ap_ready = (state == S_IDLE);
    assign ap_done  = (state == S_DONE);

    always_comb begin
        spread    = c_ask - c_bid;
        buy_px    = c_bid + TICK32;
        sell_px   = c_ask - TICK32;
        // 33-bit signed view of the position: +/- ORDER_QTY and negation
        // cannot overflow even at the 32-bit extremes.
        pos_s     = {c_pos[31], c_pos};
        neg_pos   = -pos_s;
        long_qty  = (pos_s < QTY_S) ? c_pos : QTY32;
        short_qty = (neg_pos < QTY_S) ? neg_pos[31:0] : QTY32;
        invalid   = (c_bid == '0) || (c_ask == '0) || (c_ask <= c_bid) ||
                    (spread < SPREAD32);

        n_action = '0;
        n_price  = '0;
        n_qty    = '0;
        if (!invalid) begin
            if (c_bstr && !c_astr && (pos_s + QTY_S <= MAX_S)) begin
                n_action = 32'd1;
                n_price  = buy_px;
                n_qty    = QTY32;
            end else if (c_astr && !c_bstr && (pos_s - QTY_S >= -MAX_S)) begin
                n_action = 32'd2;
                n_price  = sell_px;
                n_qty    = QTY32;
            end else if (pos_s > 33'sd0) begin
                // Do not unwind a long below the price it was bought at.
                if (!((c_lfs == 32'd1) && (c_lfp != '0) && (sell_px < c_lfp))) begin
                    n_action = 32'd2;
                    n_price  = sell_px;
                    n_qty    = long_qty;
                end
            end else if (pos_s < 33'sd0) begin
                // Do not cover a short above the price it was sold at.
                if (!((c_lfs == 32'd2) && (c_lfp != '0) && (buy_px > c_lfp))) begin
                    n_action = 32'd1;
                    n_price  = buy_px;
                    n_qty    = short_qty;
                end
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state    <= S_IDLE;
            action   <= '0;
            price    <= '0;
            quantity <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ap_start) state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    c_bid     <= best_bid_price;
                    c_ask     <= best_ask_price;
                    c_bid_qty <= best_bid_qty;
                    c_ask_qty <= best_ask_qty;
                    c_bstr    <= |bid_queue_strong;
                    c_astr    <= |ask_queue_strong;
                    c_pos     <= current_position;
                    c_lfp     <= last_fill_price;
                    c_lfs     <= last_fill_side;
                    state     <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    action   <= n_action;
                    price    <= n_price;
                    quantity <= n_qty;
                    state    <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hft_zero_plus.sv
// tb_hft_zero_plus: directed bench for hft_zero_plus with hand-computed
// expected decisions, handshake timing, reset abort and back-to-back runs.
module tb_hft_zero_plus;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        ap_start = 1'b0;
    logic        ap_done, ap_idle, ap_ready;
    logic [31:0] best_bid_price = '0, best_ask_price = '0;
    logic [31:0] best_bid_qty = '0, best_ask_qty = '0;
    logic [31:0] bid_queue_strong = '0, ask_queue_strong = '0;
    logic [31:0] current_position = '0;
    logic [31:0] last_fill_price = '0, last_fill_side = '0;
    logic [31:0] action, price, quantity;

    int n_cmp = 0;
    int n_bad = 0;

    hft_zero_plus #(
        .ORDER_QTY (10),
        .MAX_POS   (100),
        .MIN_SPREAD(2),
        .TICK      (1)
    ) dut (
        .ap_clk          (ap_clk),
        .ap_rst          (ap_rst),
        .ap_start        (ap_start),
        .ap_done         (ap_done),
        .ap_idle         (ap_idle),
        .ap_ready        (ap_ready),
        .best_bid_price  (best_bid_price),
        .best_ask_price  (best_ask_price),
        .best_bid_qty    (best_bid_qty),
        .best_ask_qty    (best_ask_qty),
        .bid_queue_strong(bid_queue_strong),
        .ask_queue_strong(ask_queue_strong),
        .current_position(current_position),
        .last_fill_price (last_fill_price),
        .last_fill_side  (last_fill_side),
        .action          (action),
        .price           (price),
        .quantity        (quantity)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] bid, input logic [31:0] ask,
                          input logic [31:0] bs, input logic [31:0] as_,
                          input logic [31:0] pos, input logic [31:0] lfp,
                          input logic [31:0] lfs);
        best_bid_price   = bid;
        best_ask_price   = ask;
        best_bid_qty     = 32'd150;
        best_ask_qty     = 32'd50;
        bid_queue_strong = bs;
        ask_queue_strong = as_;
        current_position = pos;
        last_fill_price  = lfp;
        last_fill_side   = lfs;
    endtask

    // Pulse ap_start for one sampling edge, wait (bounded) for ap_done and
    // check latency, decision and the return to idle.
    task automatic txn(input string tag,
                       input logic [31:0] bid, input logic [31:0] ask,
                       input logic [31:0] bs, input logic [31:0] as_,
                       input logic [31:0] pos, input logic [31:0] lfp,
                       input logic [31:0] lfs,
                       input logic [31:0] e_act, input logic [31:0] e_px,
                       input logic [31:0] e_qty);
        int lat;
        @(negedge ap_clk);
        set_in(bid, ask, bs, as_, pos, lfp, lfs);
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1 ap_start = 1'b0;
        lat = 99;
        for (int i = 1; i <= 10; i++) begin
            @(negedge ap_clk);
            if (ap_done === 1'b1) begin
                lat = i;
                break;
            end
        end
        check({tag, ".latency"}, 32'(lat), 32'd3);
        check({tag, ".action"}, action, e_act);
        check({tag, ".price"}, price, e_px);
        check({tag, ".qty"}, quantity, e_qty);
        @(negedge ap_clk);
        check({tag, ".done_drop"}, {31'd0, ap_done}, 32'd0);
        check({tag, ".idle_back"}, {30'd0, ap_idle, ap_ready}, 32'd3);
    endtask

    initial begin : stim
        logic [12:0] done_seen;
        logic        any_done;

        // Reset state
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        check("rst.idle_ready", {30'd0, ap_idle, ap_ready}, 32'd3);
        check("rst.done", {31'd0, ap_done}, 32'd0);
        check("rst.action", action, 32'd0);
        check("rst.price", price, 32'd0);
        check("rst.qty", quantity, 32'd0);

        // Core rules
        txn("buy",      10050, 10052, 1, 0, 0,   0, 0, 1, 10051, 10);
        txn("sell",     10000, 10004, 0, 1, 0,   0, 0, 2, 10003, 10);
        txn("r1_block", 10000, 10004, 1, 0, 95,  0, 0, 2, 10003, 10);
        txn("r1_edge",  10000, 10004, 1, 0, 90,  0, 0, 1, 10001, 10);
        txn("r2_edge",  10000, 10004, 0, 1, -32'sd90, 0, 0, 2, 10003, 10);
        txn("both_str", 10000, 10004, 1, 1, 0,   0, 0, 0, 0, 0);

        // Invalid markets (preceded by a nonzero result so the forced zeros show)
        txn("buy2",     10050, 10052, 1, 0, 0,   0, 0, 1, 10051, 10);
        txn("spread1",  10050, 10051, 1, 0, 0,   0, 0, 0, 0, 0);
        txn("buy3",     10050, 10052, 1, 0, 0,   0, 0, 1, 10051, 10);
        txn("crossed",  10052, 10050, 1, 0, 0,   0, 0, 0, 0, 0);
        txn("locked",   10050, 10050, 0, 1, 0,   0, 0, 0, 0, 0);
        txn("bid0",     0,     10,    1, 0, 0,   0, 0, 0, 0, 0);

        // Unwind rules
        txn("unw_short", 10000, 10010, 0, 0, -32'sd4, 0,     0, 1, 10001, 4);
        txn("unw_s_sup", 10000, 10010, 0, 0, -32'sd4, 10000, 2, 0, 0, 0);
        txn("unw_long",  10000, 10010, 0, 0, 3,       10005, 1, 2, 10009, 3);
        txn("unw_l_sup", 10000, 10010, 0, 0, 3,       10010, 1, 0, 0, 0);
        txn("pos_max",   10000, 10004, 1, 0, 32'h7FFF_FFFF, 0, 0, 2, 10003, 10);
        txn("pos_min",   10000, 10004, 0, 0, 32'h8000_0000, 0, 0, 1, 10001, 10);

        // Reset during COMPUTE: no done, outputs cleared
        txn("pre_abort", 10050, 10052, 1, 0, 0, 0, 0, 1, 10051, 10);
        @(negedge ap_clk);
        ap_start = 1'b1;
        @(posedge ap_clk);          // IDLE -> CAPTURE
        #1 ap_start = 1'b0;
        @(posedge ap_clk);          // CAPTURE -> COMPUTE
        #1 ap_rst = 1'b1;
        @(posedge ap_clk);          // reset applied in COMPUTE
        @(negedge ap_clk);
        check("abort.done", {31'd0, ap_done}, 32'd0);
        check("abort.idle", {30'd0, ap_idle, ap_ready}, 32'd3);
        check("abort.action", action, 32'd0);
        check("abort.price", price, 32'd0);
        check("abort.qty", quantity, 32'd0);
        ap_rst = 1'b0;
        any_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge ap_clk);
            if (ap_done !== 1'b0) any_done = 1'b1;
        end
        check("abort.no_done", {31'd0, any_done}, 32'd0);

        // Inputs changed after capture do not alter the result
        @(negedge ap_clk);
        set_in(10050, 10052, 1, 0, 0, 0, 0);
        ap_start = 1'b1;
        @(posedge ap_clk);          // IDLE -> CAPTURE
        #1 ap_start = 1'b0;
        @(posedge ap_clk);          // capture
        #1 set_in(10000, 10004, 0, 1, 0, 0, 0);
        @(negedge ap_clk);          // COMPUTE
        @(negedge ap_clk);          // DONE
        check("hold.done", {31'd0, ap_done}, 32'd1);
        check("hold.action", action, 32'd1);
        check("hold.price", price, 32'd10051);
        check("hold.qty", quantity, 32'd10);

        // Back-to-back with ap_start held high: done every 4 cycles
        repeat (2) @(negedge ap_clk);
        set_in(10000, 10004, 0, 1, 0, 0, 0);
        ap_start = 1'b1;
        done_seen = '0;
        for (int i = 0; i < 13; i++) begin
            @(negedge ap_clk);
            done_seen[i] = ap_done;
        end
        ap_start = 1'b0;
        check("b2b.pattern", {19'd0, done_seen}, 32'h0000_0444);
        check("b2b.action", action, 32'd2);
        check("b2b.price", price, 32'd10003);
        repeat (4) @(negedge ap_clk);
        check("b2b.idle", {30'd0, ap_idle, ap_ready}, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
